// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative 32-bit divider.
// Imported by the divider top and available to its users.
package div_pkg;

    localparam int XLEN        = 32;
    localparam int DIV_ITERS   = 32;
    localparam int DIV_LATENCY = 34;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/adder32.sv
// 32-bit adder/subtractor: SUM = A + B (sub=0) or A - B (sub=1).
// CARRY_OUT is the unsigned carry, so with sub=1 it means A >= B.
module adder32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sub,
    output logic [31:0] SUM,
    output logic        CARRY_OUT
);

    logic [32:0] w_full;

    assign w_full    = {1'b0, A} + {1'b0, B ^ {32{sub}}} + {32'd0, sub};
    assign SUM       = w_full[31:0];
    assign CARRY_OUT = w_full[32];

endmodule

// File: rtl/div32_iter.sv
// Restoring 32-bit divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// fixed 34-edge latency from start acceptance to the done pulse.
module div32_iter #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero,
    output logic [1:0]      dbg_state
);
    import div_pkg::*;

    // Handshake: start is sampled only in IDLE (never queued); busy covers
    // CALC and FIX; done is a one-cycle pulse and results hold until the
    // next accepted start.

    div_state_e      r_state;
    logic [5:0]      r_count;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_dvs_mag;
    logic [XLEN-1:0] r_dvd_orig;
    logic            r_signed;
    logic            r_sign_a;
    logic            r_sign_b;
    logic            r_div0;
    logic            r_ovf;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_remd;
    logic            r_dbz;

    logic [XLEN-1:0] w_rem_shift;
    logic [XLEN-1:0] w_trial_sum;
    logic            w_trial_co;
    logic            w_accept;
    logic [XLEN-1:0] w_neg_a_in;
    logic [XLEN-1:0] w_neg_b_in;
    logic [XLEN-1:0] w_neg_a_sum;
    logic [XLEN-1:0] w_neg_b_sum;
    logic            w_neg_a_co_unused;
    logic            w_neg_b_co_unused;
    logic [XLEN-1:0] w_quot_fix;
    logic [XLEN-1:0] w_rem_fix;

    // The top remainder bit leaves the register on the shift; it acts as
    // the 33rd bit of the partial remainder and forces an accept.
    assign w_rem_shift = {r_rem[XLEN-2:0], r_q[XLEN-1]};
    assign w_accept    = r_rem[XLEN-1] | w_trial_co;

    adder32 u_trial (
        .A         (w_rem_shift),
        .B         (r_dvs_mag),
        .sub       (1'b1),
        .SUM       (w_trial_sum),
        .CARRY_OUT (w_trial_co)
    );

    // Negators are shared: operand magnitudes in IDLE, result signs in FIX.
    always_comb begin
        w_neg_a_in = r_q;
        w_neg_b_in = r_rem;
        if (r_state == IDLE) begin
            w_neg_a_in = dividend;
            w_neg_b_in = divisor;
        end
    end

    adder32 u_neg_a (
        .A         (32'd0),
        .B         (w_neg_a_in),
        .sub       (1'b1),
        .SUM       (w_neg_a_sum),
        .CARRY_OUT (w_neg_a_co_unused)
    );

    adder32 u_neg_b (
        .A         (32'd0),
        .B         (w_neg_b_in),
        .sub       (1'b1),
        .SUM       (w_neg_b_sum),
        .CARRY_OUT (w_neg_b_co_unused)
    );

    always_comb begin
        w_quot_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? w_neg_a_sum : r_q;
        w_rem_fix  = (r_signed && r_sign_a) ? w_neg_b_sum : r_rem;
        if (r_div0) begin
            w_quot_fix = DIV0_QUOT;
            w_rem_fix  = r_dvd_orig;
        end else if (r_ovf) begin
            w_quot_fix = INT_MIN;
            w_rem_fix  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_dvs_mag  <= '0;
            r_dvd_orig <= '0;
            r_signed   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_remd     <= '0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_signed   <= is_signed;
                        r_sign_a   <= dividend[XLEN-1];
                        r_sign_b   <= divisor[XLEN-1];
                        r_q        <= (is_signed && dividend[XLEN-1]) ? w_neg_a_sum : dividend;
                        r_dvs_mag  <= (is_signed && divisor[XLEN-1]) ? w_neg_b_sum : divisor;
                        r_dvd_orig <= dividend;
                        r_div0     <= (divisor == '0);
                        r_ovf      <= is_signed && (dividend == INT_MIN) && (divisor == '1);
                        r_rem      <= '0;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    // The edge after the last iteration only hands over to FIX.
                    if (r_count == 6'(ITERS)) begin
                        r_state <= FIX;
                    end else begin
                        r_rem   <= w_accept ? w_trial_sum : w_rem_shift;
                        r_q     <= {r_q[XLEN-2:0], w_accept};
                        r_count <= r_count + 6'd1;
                    end
                end
                FIX: begin
                    r_quot  <= w_quot_fix;
                    r_remd  <= w_rem_fix;
                    r_dbz   <= r_div0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_dbz;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_div32_iter.sv
// Self-checking bench for div32_iter: directed cases, random operands
// against an arithmetic reference, start-ignore, back-to-back and async reset.
module tb_div32_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div32_iter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // Reference: RISC-V M-extension division rules in plain arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        z = (b == 32'd0);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drives one operation; reports results, done latency (-1 on timeout),
    // busy misbehaviour and whether done stayed high past one cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r, output logic z,
                          output int lat, output int busy_bad, output logic done_long);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = ~s;
        lat = -1; busy_bad = 0; q = '0; r = '0; z = 1'b0;
        if (busy !== 1'b1) busy_bad++;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k; q = quotient; r = remainder; z = div_by_zero;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        @(posedge clk); #1;
        done_long = done;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        #2;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta[9] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h0000_1234, 32'h0000_1234,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] tb[9] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'd1, 32'h8000_0001, 32'hFFFF_FFFF};
        logic        ts[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] eq[9] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [31:0] er[9] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'h0000_1234, 32'h0000_1234,
                               32'd0, 32'd0, 32'h7FFF_FFFE, 32'h8000_0000};
        logic        ez[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] q, r;
        logic        z, dl;
        int          lat, bb;
        for (int i = 0; i < 9; i++) begin
            run_op(ta[i], tb[i], ts[i], q, r, z, lat, bb, dl);
            n_checks++;
            if (lat !== 34) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 34", i, lat); end
            n_checks++;
            if (q !== eq[i]) begin n_fail++; $display("FAIL dir%0d_quotient: got %h want %h", i, q, eq[i]); end
            n_checks++;
            if (r !== er[i]) begin n_fail++; $display("FAIL dir%0d_remainder: got %h want %h", i, r, er[i]); end
            n_checks++;
            if (z !== ez[i]) begin n_fail++; $display("FAIL dir%0d_div_by_zero: got %b want %b", i, z, ez[i]); end
            n_checks++;
            if (bb !== 0) begin n_fail++; $display("FAIL dir%0d_busy: %0d bad cycles want 0", i, bb); end
            n_checks++;
            if (dl !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse: done still %b want 0", i, dl); end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, q, r, mq, mr;
        logic        s, z, mz, dl;
        int          lat, bb;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'd0 - $urandom_range(1, 100);
                4:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(a, b, s, mq, mr, mz);
            run_op(a, b, s, q, r, z, lat, bb, dl);
            n_checks++;
            if (lat !== 34 || bb !== 0 || dl !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_timing: got lat=%0d busy_bad=%0d done_long=%b want 34 0 0", i, lat, bb, dl);
            end
            n_checks++;
            if ({q, r, z} !== {mq, mr, mz}) begin
                n_fail++;
                $display("FAIL rnd%0d_result: a=%h b=%h s=%b got q=%h r=%h z=%b want q=%h r=%h z=%b",
                         i, a, b, s, q, r, z, mq, mr, mz);
            end
        end
    endtask

    task automatic test_ignored_start;
        logic [31:0] mq, mr, q, r;
        logic        mz;
        int          done_k;
        model(32'd1000, 32'd9, 1'b0, mq, mr, mz);
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd9; is_signed = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        done_k = -1; q = '0; r = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 34);
            dividend = $urandom; divisor = $urandom_range(1, 50); is_signed = 1'($urandom_range(0, 1));
            @(posedge clk); #1; start = 1'b0;
            if (done === 1'b1 && done_k < 0) begin done_k = k; q = quotient; r = remainder; end
        end
        n_checks++;
        if (done_k !== 34) begin n_fail++; $display("FAIL ignore_latency: got %0d want 34", done_k); end
        n_checks++;
        if (q !== mq || r !== mr) begin
            n_fail++; $display("FAIL ignore_result: got q=%h r=%h want q=%h r=%h", q, r, mq, mr);
        end
        n_checks++;
        if (quotient !== mq || remainder !== mr || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_hold: got q=%h r=%h busy=%b want q=%h r=%h busy=0", quotient, remainder, busy, mq, mr);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] q1, r1, q2, r2, mq1, mr1, mq2, mr2, a2, b2;
        logic        mz;
        int          d1, d2, n_done;
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        model(32'd77, 32'd5, 1'b0, mq1, mr1, mz);
        model(a2, b2, 1'b0, mq2, mr2, mz);
        @(negedge clk);
        start = 1'b1; dividend = 32'd77; divisor = 32'd5; is_signed = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        d1 = -1; d2 = -1; n_done = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            start = (k == 35 || k == 36);
            is_signed = 1'b0;
            dividend = (k == 36) ? a2 : 32'hDEAD_BEEF;
            divisor  = (k == 36) ? b2 : 32'd3;
            @(posedge clk); #1; start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (d1 < 0) begin d1 = k; q1 = quotient; r1 = remainder; end
                else begin d2 = k; q2 = quotient; r2 = remainder; end
            end
        end
        n_checks++;
        if (d1 !== 34 || q1 !== mq1 || r1 !== mr1) begin
            n_fail++; $display("FAIL b2b_first: got k=%0d q=%h r=%h want k=34 q=%h r=%h", d1, q1, r1, mq1, mr1);
        end
        n_checks++;
        if (d2 !== 70 || n_done !== 2) begin
            n_fail++; $display("FAIL b2b_second_timing: got k=%0d dones=%0d want k=70 dones=2", d2, n_done);
        end
        n_checks++;
        if (q2 !== mq2 || r2 !== mr2) begin
            n_fail++; $display("FAIL b2b_second_result: got q=%h r=%h want q=%h r=%h", q2, r2, mq2, mr2);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] q, r;
        logic        z, dl, saw_done;
        int          lat, bb;
        run_op(32'd100, 32'd7, 1'b0, q, r, z, lat, bb, dl);
        @(negedge clk);
        start = 1'b1; dividend = 32'd5000; divisor = 32'd0; is_signed = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL async_reset_no_done: got done=1 want 0"); end
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, z, lat, bb, dl);
        n_checks++;
        if (lat !== 34 || q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || z !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_recover: got lat=%0d q=%h r=%h z=%b want 34 fffffffd ffffffff 0", lat, q, r, z);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
